// File: rtl/satatrn_txarb_if.sv
// rtl/satatrn_txarb_if.sv - stream bundle between FIS sources, tx arbiter and link layer
interface satatrn_txarb_if;
    logic        s_reg_valid;
    logic        s_reg_ready;
    logic [31:0] s_reg_data;
    logic        s_reg_last;
    logic        s_data_valid;
    logic        s_data_ready;
    logic [31:0] s_data_data;
    logic        s_data_last;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic        o_last;

    modport slave (
        input  s_reg_valid, s_reg_data, s_reg_last,
        output s_reg_ready,
        input  s_data_valid, s_data_data, s_data_last,
        output s_data_ready,
        output o_valid, o_data, o_last,
        input  i_ready
    );

    modport master (
        output s_reg_valid, s_reg_data, s_reg_last,
        input  s_reg_ready,
        output s_data_valid, s_data_data, s_data_last,
        input  s_data_ready,
        input  o_valid, o_data, o_last,
        output i_ready
    );
endinterface

// File: rtl/satatrn_txarb.sv
// rtl/satatrn_txarb.sv - transport tx arbiter: register FIS passthrough, DATA FIS framing and abort drain
module satatrn_txarb #(
    parameter int MAXLEN = 2048
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_link_err,
    satatrn_txarb_if.slave  bus
);
    localparam int              CW       = $clog2(MAXLEN + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(MAXLEN - 1);
    localparam logic [31:0]     DATA_HDR = 32'h0000_0046;

    typedef enum logic [2:0] {
        IDLE, REG, DHDR, DATA, DRAIN_REG, DRAIN_DATA
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           mid_reg;
    logic           mid_data;

    logic           free;
    logic           reg_acc;
    logic           data_acc;
    logic           mid_reg_nxt;
    logic           mid_data_nxt;
    logic           data_end;
    logic           draining;

    assign free     = !bus.o_valid || bus.i_ready;
    assign draining = (state == DRAIN_REG) || (state == DRAIN_DATA);

    always_comb begin
        bus.s_reg_ready  = 1'b0;
        bus.s_data_ready = 1'b0;
        case (state)
            REG:        bus.s_reg_ready  = free;
            DATA:       bus.s_data_ready = free;
            DRAIN_REG:  bus.s_reg_ready  = 1'b1;
            DRAIN_DATA: bus.s_data_ready = 1'b1;
            default:    ;
        endcase
    end

    assign reg_acc  = bus.s_reg_valid && bus.s_reg_ready;
    assign data_acc = bus.s_data_valid && bus.s_data_ready;

    // Source-packet position is tracked independently of FIS splits so an abort knows what to drain.
    assign mid_reg_nxt  = reg_acc  ? !bus.s_reg_last  : mid_reg;
    assign mid_data_nxt = data_acc ? !bus.s_data_last : mid_data;
    assign data_end     = bus.s_data_last || (cnt == CNT_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            bus.o_valid <= 1'b0;
            bus.o_data  <= 32'h0;
            bus.o_last  <= 1'b0;
            cnt         <= '0;
            mid_reg     <= 1'b0;
            mid_data    <= 1'b0;
        end else begin
            mid_reg  <= mid_reg_nxt;
            mid_data <= mid_data_nxt;
            if (free) begin
                bus.o_valid <= 1'b0;
            end
            if (i_link_err && !draining) begin
                // Abort wins over any word accepted this cycle; that word is dropped, not output.
                bus.o_valid <= 1'b0;
                cnt         <= '0;
                if (mid_reg_nxt) begin
                    state <= DRAIN_REG;
                end else if (mid_data_nxt) begin
                    state <= DRAIN_DATA;
                end else begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.s_reg_valid) begin
                            state <= REG;
                        end else if (bus.s_data_valid) begin
                            state <= DHDR;
                        end
                    end
                    REG: begin
                        if (reg_acc) begin
                            bus.o_valid <= 1'b1;
                            bus.o_data  <= bus.s_reg_data;
                            bus.o_last  <= bus.s_reg_last;
                            if (bus.s_reg_last) begin
                                state <= IDLE;
                            end
                        end
                    end
                    DHDR: begin
                        if (free) begin
                            bus.o_valid <= 1'b1;
                            bus.o_data  <= DATA_HDR;
                            bus.o_last  <= 1'b0;
                            cnt         <= '0;
                            state       <= DATA;
                        end
                    end
                    DATA: begin
                        if (data_acc) begin
                            bus.o_valid <= 1'b1;
                            bus.o_data  <= bus.s_data_data;
                            bus.o_last  <= data_end;
                            cnt         <= cnt + CW'(1);
                            if (data_end) begin
                                state <= IDLE;
                            end
                        end
                    end
                    DRAIN_REG: begin
                        if (reg_acc && bus.s_reg_last) begin
                            state <= IDLE;
                        end
                    end
                    DRAIN_DATA: begin
                        if (data_acc && bus.s_data_last) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/satatrn_txarb.md
# satatrn_txarb

Transport-layer transmit FIS arbiter and framer for the SATA host. Merges a register-FIS source stream and a raw data-payload stream into one FIS stream toward the link layer. Prepends a DATA FIS header (type 8'h46) to payload words and splits payloads longer than MAXLEN dwords into consecutive DATA FISes. On a link error it aborts the current frame and drains the partially consumed source packet.

## Interface
- MAXLEN, 2048: maximum payload dwords per DATA FIS, excluding the header; legal range 1..2048.
- i_clk  input  1  single system clock; all logic on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_link_err  input  1  link layer aborted the current frame; one-cycle pulse or level.
- s_reg_valid  input  1  register FIS word available.
- s_reg_ready  output  1  register word accepted this cycle when valid&&ready.
- s_reg_data  input  32  register FIS word, little endian; byte 0 of word 0 is the FIS type.
- s_reg_last  input  1  final word of the register FIS.
- s_data_valid  input  1  payload word available.
- s_data_ready  output  1  payload word accepted when valid&&ready.
- s_data_data  input  32  payload dword, little endian.
- s_data_last  input  1  final payload dword of the transfer.
- o_valid  output  1  FIS word to the link layer.
- i_ready  input  1  link layer accepts o_data.
- o_data  output  32  FIS word, little endian.
- o_last  output  1  final word of the FIS.

## Operation
- States: IDLE, REG, DHDR, DATA, DRAIN_REG, DRAIN_DATA.
- Output stage: o_valid, o_data and o_last are registers. The stage is "free" when !o_valid || i_ready.
- The output registers load only when free. Otherwise they hold stable.
- When free and nothing is loaded, o_valid drops to 0.
- IDLE:
  - If s_reg_valid, go to REG. Register traffic has priority when both sources are valid.
  - Else if s_data_valid, go to DHDR.
  - No word is consumed in IDLE.
- REG:
  - s_reg_ready = free.
  - On accept, load {s_reg_last, s_reg_data}.
  - If s_reg_last, go to IDLE.
  - No length limit applies.
- DHDR:
  - When free, load header 32'h0000_0046 with o_last=0.
  - Clear the payload counter and go to DATA.
  - s_data_ready = 0.
- DATA:
  - s_data_ready = free.
  - On accept, load s_data_data and increment the counter.
  - o_last = s_data_last || (counter == MAXLEN-1).
  - On o_last, go to IDLE.
  - If the split was caused by the counter (source not at last), the next payload words start a fresh DATA FIS through IDLE→DHDR. A pending register FIS may win arbitration in between.
- Source tracking: flags mid_reg and mid_data.
  - Set on acceptance of a non-last word; cleared on acceptance of a last word.
  - Splitting does not clear mid_data.
- i_link_err, any state except the DRAIN states:
  - o_valid clears next cycle.
  - Counter clears.
  - If mid_reg, go to DRAIN_REG; else if mid_data, go to DRAIN_DATA; else go to IDLE.
  - DHDR with no word consumed goes to IDLE.
- DRAIN_x:
  - The corresponding ready = 1 and the other ready = 0.
  - Words are discarded, never output.
  - When the last word is accepted, clear the flag and go to IDLE.
  - i_link_err in the DRAIN states has no additional effect.
- Counter width: $clog2(MAXLEN+1) bits. It never exceeds MAXLEN-1 when compared.

## Timing
- Reset values:
  - state=IDLE, o_valid=0, o_data=0, o_last=0.
  - s_reg_ready=0, s_data_ready=0.
  - counter=0, mid_reg=0, mid_data=0.
- Latency:
  - An accepted source word appears on o_data the cycle after acceptance.
  - IDLE adds one bubble cycle per FIS start.
  - A DATA FIS start costs 2 cycles to the header: IDLE, then DHDR loads it.
- Throughput: one word per cycle within a FIS while i_ready=1.
- Backpressure: with o_valid && !i_ready, o_data and o_last hold stable and both readies are 0, except in the DRAIN states.
- Simultaneous i_link_err and accept in the same cycle: the error wins.
  - The output word is not loaded (o_valid=0 next cycle).
  - The source word counts as consumed for the mid_* flags, so a last word accepted this cycle leads to IDLE, not DRAIN.
- Asynchronous reset mid-FIS: outputs go to reset values immediately. No drain follows.

## Test plan
- Register FIS: 5 words (0x0080_EC27, 1, 2, 3, 4 with last) and i_ready=1 → o_data carries the same 5 words, o_last on word 5, first word 2 cycles after s_reg_valid rises.
- DATA FIS: 3 payload words (A, B, C with last) → 0x0000_0046, A, B, C, with o_last only on C.
- Both sources valid in the same cycle → the complete register FIS is output before the DATA header.
- Split: MAXLEN=2, 5 payload words d0..d4 → H, d0, d1(last), H, d2, d3(last), H, d4(last).
- Random i_ready toggling during a 16-word DATA transfer → no dropped or duplicated words, and the output stays stable while stalled.
- i_link_err after 2 of 6 payload words → o_valid=0 next cycle, remaining 4 words drained with s_data_ready=1 and no output, state returns to IDLE, and the next register FIS passes normally.
